// File: rtl/jump_offset_pkg.sv
// Shared types and helpers for the jump-offset bank.
// State encoding for the output handshake plus index-width helper.
package jump_offset_pkg;

   localparam int DEFAULT_DATA_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } jump_state_e;

   // Index width that stays at least one bit wide even for a single-entry bank.
   function automatic int clog2_max1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/jump_offset_bank_if.sv
// Decode-side request/offset-write bus and fetch-side result bus of the jump-offset bank.
// JumpMisalign exists only when JUMP_MISALIGN_CHK_EN is defined.
interface jump_offset_bank_if
   import jump_offset_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int NUM_OFFSETS = 4
);
   localparam int IDX_W = clog2_max1(NUM_OFFSETS);

   logic              OffsetWrEn;
   logic [IDX_W-1:0]  OffsetWrIdx;
   logic [DATA_W-1:0] OffsetWrData;
   logic              JumpReq;
   logic              JumpReqRdy;
   logic [IDX_W-1:0]  JumpIdx;
   logic [DATA_W-1:0] JumpBase;
   logic              JumpFlush;
   logic              NewJumpValid;
   logic              NewJumpRdy;
   logic [DATA_W-1:0] NewJumpADDR;
`ifdef JUMP_MISALIGN_CHK_EN
   logic              JumpMisalign;
`endif

   modport slave (
      input  OffsetWrEn, OffsetWrIdx, OffsetWrData,
      input  JumpReq, JumpIdx, JumpBase, JumpFlush, NewJumpRdy,
      output JumpReqRdy, NewJumpValid, NewJumpADDR
`ifdef JUMP_MISALIGN_CHK_EN
      , output JumpMisalign
`endif
   );

   modport master (
      output OffsetWrEn, OffsetWrIdx, OffsetWrData,
      output JumpReq, JumpIdx, JumpBase, JumpFlush, NewJumpRdy,
      input  JumpReqRdy, NewJumpValid, NewJumpADDR
`ifdef JUMP_MISALIGN_CHK_EN
      , input  JumpMisalign
`endif
   );

endinterface

// File: rtl/jump_offset_regfile.sv
// NUM_OFFSETS x DATA_W offset registers: one write port, one combinational read port.
// Read sees a same-cycle write to the same index; out-of-range indices read 0 / ignore writes.
module jump_offset_regfile
   import jump_offset_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int NUM_OFFSETS = 4,
   parameter int IDX_W       = clog2_max1(NUM_OFFSETS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] offs_q [NUM_OFFSETS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_OFFSETS; i++) begin
            offs_q[i] <= '0;
         end
      end else if (wr_en_i && (int'(wr_idx_i) < NUM_OFFSETS)) begin
         offs_q[wr_idx_i] <= wr_data_i;
      end
   end

   always_comb begin
      rd_data_o = '0;
      if (int'(rd_idx_i) < NUM_OFFSETS) begin
         if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
            rd_data_o = wr_data_i;
         end else begin
            rd_data_o = offs_q[rd_idx_i];
         end
      end
   end

endmodule

// File: rtl/jump_offset_bank.sv
// Jump-target generator: registers JumpBase + selected offset into a 1-deep output slot (1-cycle latency).
// Request side is ready whenever the slot is empty or being drained; JUMP_MISALIGN_CHK_EN adds JumpMisalign.
module jump_offset_bank
   import jump_offset_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int NUM_OFFSETS = 4
) (
   input  logic               CLK,
   input  logic               RST,
   jump_offset_bank_if.slave  bus
);

   localparam int IDX_W = clog2_max1(NUM_OFFSETS);

   jump_state_e       state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] off;
   logic [DATA_W-1:0] sum;
   logic              req_rdy;
   logic              accept;

   jump_offset_regfile #(
      .DATA_W      (DATA_W),
      .NUM_OFFSETS (NUM_OFFSETS),
      .IDX_W       (IDX_W)
   ) u_regfile (
      .clk       (CLK),
      .rst       (RST),
      .wr_en_i   (bus.OffsetWrEn),
      .wr_idx_i  (bus.OffsetWrIdx),
      .wr_data_i (bus.OffsetWrData),
      .rd_idx_i  (bus.JumpIdx),
      .rd_data_o (off)
   );

   assign sum     = bus.JumpBase + off;
   assign req_rdy = (state_q == IDLE) | bus.NewJumpRdy;
   assign accept  = bus.JumpReq & req_rdy & ~bus.JumpFlush;

`ifdef JUMP_MISALIGN_CHK_EN
   logic mis_q, mis_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
`ifdef JUMP_MISALIGN_CHK_EN
      mis_d   = mis_q;
`endif
      // Flush beats both a new accept and a pending drain.
      if (bus.JumpFlush) begin
         state_d = IDLE;
`ifdef JUMP_MISALIGN_CHK_EN
         mis_d   = 1'b0;
`endif
      end else if (accept) begin
         state_d = HOLD;
         addr_d  = sum;
`ifdef JUMP_MISALIGN_CHK_EN
         mis_d   = |sum[1:0];
`endif
      end else if ((state_q == HOLD) && bus.NewJumpRdy) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
`ifdef JUMP_MISALIGN_CHK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
`ifdef JUMP_MISALIGN_CHK_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign bus.JumpReqRdy   = req_rdy;
   assign bus.NewJumpValid = (state_q == HOLD);
   assign bus.NewJumpADDR  = addr_q;
`ifdef JUMP_MISALIGN_CHK_EN
   assign bus.JumpMisalign = mis_q;
`endif

endmodule
